// File: rtl/derived_clock_pkg.sv
// derived_clock_pkg: shared widths, FSM state type and the zero-to-one
// sanitizing helper for the derived clock controller.
package derived_clock_pkg;

    localparam int unsigned N_W   = 32;
    localparam int unsigned DIV_W = 8;

    typedef enum logic [1:0] {
        StIdle     = 2'd0,
        StRun      = 2'd1,
        StStopping = 2'd2
    } state_e;

    // A zero setting behaves as 1 so a half-period is never empty.
    function automatic logic [N_W-1:0] sat_one(input logic [N_W-1:0] v);
        return (v == '0) ? N_W'(1) : v;
    endfunction

endpackage

// File: rtl/derived_clock_ctrl_if.sv
// derived_clock_ctrl_if: valid/ready settings channel from the register
// interface to the derived clock controller.
interface derived_clock_ctrl_if;
    import derived_clock_pkg::*;

    logic             cfg_valid;
    logic             cfg_ready;
    logic [N_W-1:0]   cfg_n;
    logic [DIV_W-1:0] cfg_div;

    modport master (
        output cfg_valid,
        output cfg_n,
        output cfg_div,
        input  cfg_ready
    );

    modport slave (
        input  cfg_valid,
        input  cfg_n,
        input  cfg_div,
        output cfg_ready
    );

endinterface

// File: rtl/derived_clock_core.sv
// derived_clock_core: nested cnt/dcnt half-period counter, boundary detect
// and the registered out_clk toggle. Counters are parked at 1 while disabled.
module derived_clock_core
    import derived_clock_pkg::*;
#(
    parameter logic IDLE_LEVEL = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en_i,
    input  logic [N_W-1:0]   n_eff_i,
    input  logic [DIV_W-1:0] div_eff_i,
    output logic             boundary_o,
    output logic             next_level_o,
    output logic             out_clk_o,
    output logic             tick_o
);

    logic [N_W-1:0]   cnt_q, cnt_d;
    logic [DIV_W-1:0] dcnt_q, dcnt_d;
    logic             out_q, out_d;
    logic             tick_q;
    logic             cnt_max, dcnt_max;

    assign cnt_max      = (cnt_q == n_eff_i);
    assign dcnt_max     = (dcnt_q == div_eff_i);
    assign boundary_o   = en_i & cnt_max & dcnt_max;
    assign next_level_o = ~out_q;
    assign out_clk_o    = out_q;
    assign tick_o       = tick_q;

    // Advance the nested counters; toggle only when both sit at their limits.
    always_comb begin
        cnt_d  = cnt_q;
        dcnt_d = dcnt_q;
        out_d  = out_q;
        if (!en_i) begin
            cnt_d  = N_W'(1);
            dcnt_d = DIV_W'(1);
        end else if (!cnt_max) begin
            cnt_d = cnt_q + N_W'(1);
        end else if (!dcnt_max) begin
            cnt_d  = N_W'(1);
            dcnt_d = dcnt_q + DIV_W'(1);
        end else begin
            cnt_d  = N_W'(1);
            dcnt_d = DIV_W'(1);
            out_d  = ~out_q;
        end
    end

    // Counter, output clock and tick registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= N_W'(1);
            dcnt_q <= DIV_W'(1);
            out_q  <= IDLE_LEVEL;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            dcnt_q <= dcnt_d;
            out_q  <= out_d;
            tick_q <= boundary_o;
        end
    end

endmodule

// File: rtl/derived_clock_ctrl.sv
// derived_clock_ctrl: run/stop FSM, shadow settings register and cfg handshake
// around derived_clock_core. Settings written while running wait in the shadow
// and are applied only at an out_clk toggle, so no runt pulse is produced.
// Optional feature: define DERIVED_CLOCK_CTRL_PERIOD_CNT_EN to add period_cnt.
module derived_clock_ctrl
    import derived_clock_pkg::*;
#(
    parameter logic [N_W-1:0]   N_RESET    = 32'd1,
    parameter logic [DIV_W-1:0] DIV_RESET  = 8'd9,
    parameter logic             IDLE_LEVEL = 1'b1
) (
    input  logic                   clk,
    input  logic                   rst,
    derived_clock_ctrl_if.slave    cfg,
    input  logic                   start,
    input  logic                   stop,
    output logic                   out_clk,
    output logic                   tick,
    output logic                   running,
    output logic                   cfg_pending
`ifdef DERIVED_CLOCK_CTRL_PERIOD_CNT_EN
    ,
    output logic [N_W-1:0]         period_cnt
`endif
);

    state_e           state_q, state_d;
    logic [N_W-1:0]   n_q, n_d, sh_n_q, sh_n_d;
    logic [DIV_W-1:0] div_q, div_d, sh_div_q, sh_div_d;
    logic             pending_q, pending_d;
    logic [N_W-1:0]   n_eff;
    logic [DIV_W-1:0] div_eff;
    logic             hs, boundary, next_level, lands_idle;

    assign n_eff       = sat_one(n_q);
    assign div_eff     = DIV_W'(sat_one(N_W'(div_q)));
    assign hs          = cfg.cfg_valid & ~pending_q;
    assign cfg.cfg_ready = ~pending_q;
    assign cfg_pending = pending_q;
    assign running     = (state_q != StIdle);
    // Toggle that brings out_clk back to its parking level.
    assign lands_idle  = boundary & (next_level == IDLE_LEVEL);

    derived_clock_core #(
        .IDLE_LEVEL (IDLE_LEVEL)
    ) u_core (
        .clk          (clk),
        .rst          (rst),
        .en_i         (running),
        .n_eff_i      (n_eff),
        .div_eff_i    (div_eff),
        .boundary_o   (boundary),
        .next_level_o (next_level),
        .out_clk_o    (out_clk),
        .tick_o       (tick)
    );

    // Next state: stop has priority; STOPPING parks only on an idle-level toggle.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (start && !stop) state_d = StRun;
            end
            StRun: begin
                if (stop) state_d = lands_idle ? StIdle : StStopping;
            end
            StStopping: begin
                if (start && !stop) state_d = StRun;
                else if (lands_idle) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Settings path: direct write in IDLE, shadowed and boundary-applied otherwise.
    always_comb begin
        n_d       = n_q;
        div_d     = div_q;
        sh_n_d    = sh_n_q;
        sh_div_d  = sh_div_q;
        pending_d = pending_q;
        if (state_q == StIdle) begin
            if (hs) begin
                n_d   = cfg.cfg_n;
                div_d = cfg.cfg_div;
            end
        end else begin
            if (boundary && pending_q) begin
                n_d       = sh_n_q;
                div_d     = sh_div_q;
                pending_d = 1'b0;
            end
            // hs implies the shadow was empty, so it never collides with the apply.
            if (hs) begin
                sh_n_d    = cfg.cfg_n;
                sh_div_d  = cfg.cfg_div;
                pending_d = 1'b1;
            end
        end
    end

    // FSM, active settings and shadow registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            n_q       <= N_RESET;
            div_q     <= DIV_RESET;
            sh_n_q    <= '0;
            sh_div_q  <= '0;
            pending_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            n_q       <= n_d;
            div_q     <= div_d;
            sh_n_q    <= sh_n_d;
            sh_div_q  <= sh_div_d;
            pending_q <= pending_d;
        end
    end

`ifdef DERIVED_CLOCK_CTRL_PERIOD_CNT_EN
    logic [N_W-1:0] period_q, period_d;

    assign period_cnt = period_q;

    // Count full periods; restart the count on each start from IDLE.
    always_comb begin
        period_d = period_q;
        if (state_q == StIdle && state_d == StRun) begin
            period_d = '0;
        end else if (lands_idle) begin
            period_d = period_q + N_W'(1);
        end
    end

    // Period counter register.
    always_ff @(posedge clk) begin
        if (rst) period_q <= '0;
        else     period_q <= period_d;
    end
`endif

endmodule

// File: tb/tb_derived_clock_ctrl.sv
// tb_derived_clock_ctrl: table-driven vectors, directed corner sequences and
// random stimulus, all checked every cycle against an elapsed-time model.
module tb_derived_clock_ctrl;
    import derived_clock_pkg::*;

    localparam logic IDLE = 1'b1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1, valid = 1'b0, start = 1'b0, stop = 1'b0;
    logic [31:0] n_in = '0;
    logic [7:0]  div_in = '0;
    logic        out_clk, tick, running, cfg_pending, cfg_ready;
`ifdef DERIVED_CLOCK_CTRL_PERIOD_CNT_EN
    logic [31:0] period_cnt;
`endif

    derived_clock_ctrl_if cfg_if ();
    assign cfg_if.cfg_valid = valid;
    assign cfg_if.cfg_n     = n_in;
    assign cfg_if.cfg_div   = div_in;
    assign cfg_ready        = cfg_if.cfg_ready;

    derived_clock_ctrl #(
        .N_RESET    (32'd1),
        .DIV_RESET  (8'd9),
        .IDLE_LEVEL (IDLE)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .cfg         (cfg_if),
        .start       (start),
        .stop        (stop),
        .out_clk     (out_clk),
        .tick        (tick),
        .running     (running),
        .cfg_pending (cfg_pending)
`ifdef DERIVED_CLOCK_CTRL_PERIOD_CNT_EN
        ,
        .period_cnt  (period_cnt)
`endif
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Reference model: state 0=idle 1=run 2=stopping; el = cycles elapsed in half-period.
    int          m_state = 0;
    logic        m_out = IDLE, m_tick = 1'b0, m_pend = 1'b0;
    longint      m_el = 0;
    logic [31:0] m_n = 32'd1, m_sn = '0, m_per = '0;
    logic [7:0]  m_div = 8'd9, m_sd = '0;

    function automatic longint eff(input longint v);
        return (v == 0) ? 64'sd1 : v;
    endfunction

    task automatic model_step();
        bit     hs, act, bnd, nout, land;
        int     ns;
        longint hp;
        if (rst) begin
            m_state = 0; m_out = IDLE; m_tick = 0; m_pend = 0; m_el = 0;
            m_n = 32'd1; m_div = 8'd9; m_sn = '0; m_sd = '0; m_per = '0;
            return;
        end
        hs   = valid && !m_pend;
        act  = (m_state != 0);
        hp   = eff(longint'(m_n)) * eff(longint'(m_div));
        bnd  = act && (m_el == hp - 1);
        nout = bnd ? ~m_out : m_out;
        land = bnd && (nout == IDLE);
        ns   = m_state;
        case (m_state)
            0:       if (start && !stop) ns = 1;
            1:       if (stop) ns = land ? 0 : 2;
            default: if (start && !stop) ns = 1; else if (land) ns = 0;
        endcase
        if (m_state == 0) begin
            if (hs) begin m_n = n_in; m_div = div_in; end
        end else begin
            if (bnd && m_pend) begin m_n = m_sn; m_div = m_sd; m_pend = 0; end
            if (hs) begin m_sn = n_in; m_sd = div_in; m_pend = 1; end
        end
        if (m_state == 0 && ns == 1) m_per = '0;
        else if (land) m_per = m_per + 32'd1;
        m_el    = (!act || bnd) ? 64'sd0 : m_el + 1;
        m_tick  = bnd;
        m_out   = nout;
        m_state = ns;
    endtask

    // One clock: sample after the edge, advance the model, compare everything.
    task automatic step();
        @(posedge clk);
        #1;
        model_step();
        chk("out_clk", 32'(out_clk), 32'(m_out));
        chk("tick", 32'(tick), 32'(m_tick));
        chk("running", 32'(running), 32'(m_state != 0));
        chk("cfg_ready", 32'(cfg_ready), 32'(!m_pend));
        chk("cfg_pending", 32'(cfg_pending), 32'(m_pend));
`ifdef DERIVED_CLOCK_CTRL_PERIOD_CNT_EN
        chk("period_cnt", period_cnt, m_per);
`endif
    endtask

    task automatic wait_tick(input int max_steps, output int steps);
        steps = 0;
        do begin
            step();
            steps++;
        end while (!tick && steps < max_steps);
        if (!tick) chk("wait_tick_timeout", 32'(tick), 32'd1);
    endtask

    task automatic setup_run(input logic [31:0] n, input logic [7:0] d);
        rst = 1; step(); rst = 0;
        valid = 1; n_in = n; div_in = d; step(); valid = 0;
        start = 1; step(); start = 0;
    endtask

    typedef struct {
        logic        rst, valid, start, stop;
        logic [31:0] n;
        logic [7:0]  dv;
        logic        out, tk, run, rdy, pend;
    } vec_t;
    vec_t vecs[$];

    function automatic void add(input logic r, input logic v, input logic s, input logic p,
                                input logic [31:0] n, input logic [7:0] d, input logic o,
                                input logic t, input logic ru, input logic rd, input logic pe);
        vec_t x;
        x.rst = r; x.valid = v; x.start = s; x.stop = p; x.n = n; x.dv = d;
        x.out = o; x.tk = t; x.run = ru; x.rdy = rd; x.pend = pe;
        vecs.push_back(x);
    endfunction

    initial begin
        int k, ticks;
        // rst valid start stop n div | out tick run ready pend
        add(1, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0);
        add(0, 1, 0, 0, 2, 3, 1, 0, 0, 1, 0);
        add(0, 0, 1, 0, 0, 0, 1, 0, 1, 1, 0);
        for (int i = 0; i < 5; i++) add(0, 0, 0, 0, 0, 0, 1, 0, 1, 1, 0);
        add(0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 0);
        for (int i = 0; i < 5; i++) add(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0);
        add(0, 0, 0, 0, 0, 0, 1, 1, 1, 1, 0);
        add(0, 0, 0, 1, 0, 0, 1, 0, 1, 1, 0);
        for (int i = 0; i < 4; i++) add(0, 0, 0, 0, 0, 0, 1, 0, 1, 1, 0);
        add(0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 0);
        for (int i = 0; i < 5; i++) add(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0);
        add(0, 0, 0, 0, 0, 0, 1, 1, 0, 1, 0);
        add(0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0);

        foreach (vecs[i]) begin
            rst = vecs[i].rst; valid = vecs[i].valid; start = vecs[i].start;
            stop = vecs[i].stop; n_in = vecs[i].n; div_in = vecs[i].dv;
            step();
            chk($sformatf("vec%0d_out", i), 32'(out_clk), 32'(vecs[i].out));
            chk($sformatf("vec%0d_tick", i), 32'(tick), 32'(vecs[i].tk));
            chk($sformatf("vec%0d_running", i), 32'(running), 32'(vecs[i].run));
            chk($sformatf("vec%0d_ready", i), 32'(cfg_ready), 32'(vecs[i].rdy));
            chk($sformatf("vec%0d_pending", i), 32'(cfg_pending), 32'(vecs[i].pend));
        end
        rst = 0; valid = 0; start = 0; stop = 0;

        // Mid-half-period reconfiguration to N=1, DIV=1.
        setup_run(2, 3);
        wait_tick(20, k); chk("a_first_tick", k, 6); chk("a_out_low", 32'(out_clk), 0);
        step(); step();
        valid = 1; n_in = 1; div_in = 1; step(); valid = 0;
        chk("a_ready_low", 32'(cfg_ready), 0); chk("a_pending", 32'(cfg_pending), 1);
        wait_tick(20, k); chk("a_old_half", k, 3); chk("a_ready_at_tick", 32'(cfg_ready), 1);
        for (int i = 0; i < 3; i++) begin
            wait_tick(4, k); chk("a_fast_half", k, 1);
        end

        // Handshake in the tick cycle keeps old settings one more half-period.
        setup_run(2, 3);
        wait_tick(20, k); chk("b_first_tick", k, 6);
        valid = 1; n_in = 1; div_in = 2; step(); valid = 0;
        chk("b_pending", 32'(cfg_pending), 1);
        wait_tick(20, k); chk("b_old_half", k, 5);
        wait_tick(20, k); chk("b_new_half", k, 2);
        wait_tick(20, k); chk("b_new_half2", k, 2);

        // Stop while out_clk is away from the idle level.
        setup_run(2, 3);
        wait_tick(20, k); chk("c_out_low", 32'(out_clk), 0);
        stop = 1; step(); stop = 0;
        chk("c_stopping_running", 32'(running), 1);
        wait_tick(20, k); chk("c_stop_latency", k, 5);
        chk("c_idle_running", 32'(running), 0); chk("c_idle_out", 32'(out_clk), 1);
        step(); chk("c_stays_idle", 32'(running), 0);

        // Zero settings act as 1; start+stop together in IDLE stays IDLE.
        rst = 1; step(); rst = 0;
        valid = 1; n_in = 0; div_in = 0; step(); valid = 0;
        start = 1; step(); start = 0;
        wait_tick(4, k); chk("d_first_tick", k, 1);
        for (int i = 0; i < 3; i++) begin
            wait_tick(3, k); chk("d_every_cycle", k, 1);
        end
        rst = 1; step(); rst = 0;
        start = 1; stop = 1; step(); start = 0; stop = 0;
        chk("d_start_stop_idle", 32'(running), 0);
        step(); chk("d_still_idle", 32'(running), 0);

        // Reset mid-RUN with a pending shadow restores reset settings.
        setup_run(2, 3);
        step(); step();
        valid = 1; n_in = 4; div_in = 4; step(); valid = 0;
        chk("e_pending_before", 32'(cfg_pending), 1);
        rst = 1; step(); rst = 0;
        chk("e_out", 32'(out_clk), 1); chk("e_pending", 32'(cfg_pending), 0);
        chk("e_ready", 32'(cfg_ready), 1); chk("e_running", 32'(running), 0);
`ifdef DERIVED_CLOCK_CTRL_PERIOD_CNT_EN
        chk("e_period", period_cnt, 0);
`endif
        start = 1; step(); start = 0;
        wait_tick(20, k); chk("e_reset_half", k, 9);

        // Maximum N does not wrap the counter.
        rst = 1; step(); rst = 0;
        valid = 1; n_in = 32'hFFFF_FFFF; div_in = 1; step(); valid = 0;
        start = 1; step(); start = 0;
        ticks = 0;
        for (int i = 0; i < 50; i++) begin
            step();
            if (tick) ticks++;
        end
        chk("f_no_tick", ticks, 0); chk("f_running", 32'(running), 1);

        // Random stimulus against the model.
        rst = 1; step(); rst = 0;
        for (int i = 0; i < 3000; i++) begin
            rst    = ($urandom_range(0, 99) == 0);
            valid  = ($urandom_range(0, 2) == 0);
            n_in   = $urandom_range(0, 3);
            div_in = 8'($urandom_range(0, 3));
            start  = ($urandom_range(0, 4) == 0);
            stop   = ($urandom_range(0, 8) == 0);
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/derived_clock_ctrl.md
# derived_clock_ctrl

Run-time controller for a programmable derived clock: a divided output clock of half-period N×DIV system cycles, with start/stop sequencing and glitch-free reconfiguration. Register-bus writes of the divider settings are buffered in a shadow register and applied only at an output toggle boundary, so no runt pulse is ever produced. Stop requests complete the current half-period and park the output at a defined idle level. Sits between the register interface and the derived-clock consumers.

## Interface
Parameters:
- N_RESET, 1: N value loaded at reset (32 bit).
- DIV_RESET, 9: DIV value loaded at reset (8 bit).
- IDLE_LEVEL, 1'b1: out_clk level in reset, IDLE and after stop.

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- cfg_valid  in  1  new settings offered.
- cfg_ready  out  1  shadow register empty; transfer on cfg_valid & cfg_ready.
- cfg_n  in  32  requested N.
- cfg_div  in  8  requested DIV.
- start  in  1  level-sampled run request.
- stop  in  1  level-sampled stop request.
- out_clk  out  1  derived clock, registered.
- tick  out  1  one-cycle pulse in the cycle out_clk shows a new value.
- running  out  1  state is RUN or STOPPING.
- cfg_pending  out  1  shadow holds settings not yet applied.
- period_cnt  out  32  completed full periods (only with macro, see Configuration).

## Operation
- States: IDLE, RUN, STOPPING.
- Effective values: n_eff = max(N,1), div_eff = max(DIV,1); 0 is treated as 1.
- Counters cnt (32 b) and dcnt (8 b) run 1..n_eff and 1..div_eff. When cnt<n_eff: cnt+1. When cnt==n_eff and dcnt<div_eff: cnt←1, dcnt+1. When both are at max: cnt←1, dcnt←1, out_clk toggles, tick=1.
- A toggle is a boundary. At a boundary, a pending shadow is copied into the active registers and cfg_pending clears. The new values govern the next half-period.
- IDLE: counters held at 1 and out_clk=IDLE_LEVEL. A cfg handshake writes the active registers directly, so cfg_ready stays 1. start moves the state to RUN.
- RUN: a cfg handshake loads the shadow. cfg_ready=0 until the next boundary. A handshake in the same cycle as a boundary is applied at the following boundary. stop moves the state to STOPPING. start is ignored.
- STOPPING: counting continues and cfg handling is as in RUN. At a boundary where the new out_clk==IDLE_LEVEL, the state moves to IDLE and any pending shadow is applied. Otherwise the state stays in STOPPING until the next boundary. start without stop returns the state to RUN.
- start and stop in the same cycle: stop wins, so IDLE stays IDLE.
- Reset, including mid-operation: state=IDLE, out_clk=IDLE_LEVEL, tick=0, running=0, cfg_ready=1, cfg_pending=0, active N/DIV = N_RESET/DIV_RESET, shadow cleared, period_cnt=0.

## Timing
- start sampled in cycle t: running=1 at t+1 with cnt=dcnt=1. The first toggle is visible at t+n_eff×div_eff+1.
- Half-period is n_eff×div_eff cycles; full period is twice that.
- Counter width is exact; N=2^32−1 is legal and does not wrap.
- cfg_ready falls the cycle after a RUN-state handshake. It rises in the cycle tick=1 that applied the shadow.
- Stop latency: at most 2 half-periods, ending with out_clk=IDLE_LEVEL and running=0 in the same cycle as the final tick.

## Configuration
- DERIVED_CLOCK_CTRL_PERIOD_CNT_EN defined: the period_cnt port exists.
  - It increments when out_clk returns to IDLE_LEVEL.
  - It wraps 2^32−1→0.
  - It clears on reset and on start from IDLE.
- Macro undefined: the port and its logic are absent; all other behaviour is identical.

## Structure
- Package derived_clock_pkg holds:
  - the state enum;
  - N_W=32 and DIV_W=8;
  - the function sanitizing 0→1.
- Sub-module derived_clock_core holds the cnt/dcnt pair, the boundary detect and the out_clk toggle register. It takes an enable and active N/DIV and outputs a boundary pulse.
- derived_clock_ctrl holds the FSM, shadow register and handshake.

## Test plan
- Reset, then start with N=2, DIV=3 → first tick 7 cycles after start; out_clk toggles every 6 cycles.
- In RUN with N=2, DIV=3, write N=1, DIV=1 mid-half-period → cfg_ready=0; the current half-period stays 6 cycles, then toggles every cycle; cfg_ready=1 at that boundary.
- cfg handshake in the same cycle as a tick → the old settings hold for one more half-period, and the new ones apply at the next boundary.
- stop asserted while out_clk=!IDLE_LEVEL → STOPPING, then IDLE at the next tick with out_clk=1 and running=0. Stop while out_clk=IDLE_LEVEL → two ticks before IDLE.
- N=0, DIV=0 written in IDLE, then start → toggle every cycle; start+stop together in IDLE → stays IDLE.
- Reset asserted mid-RUN with a pending shadow → the next cycle shows out_clk=1, cfg_pending=0, period_cnt=0 and DIV back to 9.
